// File: rtl/trace_retire_funnel_pkg.sv
// Shared widths and lane helpers for the retire-trace funnel.
// Lane masks are padded to the largest supported lane count.
package trace_retire_funnel_pkg;

  localparam int MAX_LANES = 4;
  localparam int PRIV_W    = 3;

  typedef logic [MAX_LANES-1:0] lane_mask_t;
  typedef logic [2:0]           lane_cnt_t;

  // Record layout: {gap, iaddr, insn, priv, exception, interrupt, cause, tval}
  function automatic int rec_width(input int iaddr_w, input int insn_w, input int cause_w);
    return 1 + iaddr_w + insn_w + PRIV_W + 2 + cause_w + iaddr_w;
  endfunction

  function automatic lane_cnt_t popcount(input lane_mask_t m);
    lane_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) c = c + lane_cnt_t'(m[i]);
    return c;
  endfunction

  // Slot of a lane within the compacted burst: number of valid lanes older than it.
  function automatic lane_cnt_t lane_slot(input lane_mask_t m, input int lane);
    lane_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++)
      if (i < lane) c = c + lane_cnt_t'(m[i]);
    return c;
  endfunction

endpackage

// File: rtl/trace_retire_funnel_rec_ram.sv
// Record storage for the funnel: one write port per lane, one async read port.
// Storage is intentionally unreset; occupancy is tracked by the pointers.
module trace_rec_ram #(
  parameter int NLANES = 2,
  parameter int DEPTH  = 8,
  parameter int REC_W  = 182,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic [NLANES-1:0]       wr_en,
  input  logic [NLANES*AW-1:0]    wr_addr,
  input  logic [NLANES*REC_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic [REC_W-1:0]        rd_data
);

  logic [REC_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int j = 0; j < NLANES; j++)
      if (wr_en[j]) mem[wr_addr[j*AW +: AW]] <= wr_data[j*REC_W +: REC_W];
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_retire_funnel.sv
// Compacts valid retire lanes into a FIFO and drains one record per cycle.
// A cycle that does not fit is dropped whole and counted; the core is never stalled.
module trace_retire_funnel
  import trace_retire_funnel_pkg::*;
#(
  parameter int NLANES  = 2,
  parameter int DEPTH   = 8,
  parameter int IADDR_W = 40,
  parameter int INSN_W  = 32,
  parameter int CAUSE_W = 64,
  parameter int CNT_W   = 16,
  localparam int REC_W  = rec_width(IADDR_W, INSN_W, CAUSE_W),
  localparam int AW     = $clog2(DEPTH),
  localparam int PTR_W  = AW + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NLANES-1:0]         in_valid,
  input  logic [NLANES*IADDR_W-1:0] in_iaddr,
  input  logic [NLANES*INSN_W-1:0]  in_insn,
  input  logic [NLANES*3-1:0]       in_priv,
  input  logic [NLANES-1:0]         in_exception,
  input  logic [NLANES-1:0]         in_interrupt,
  input  logic [NLANES*CAUSE_W-1:0] in_cause,
  input  logic [NLANES*IADDR_W-1:0] in_tval,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REC_W-1:0]          out_rec,
  output logic [PTR_W-1:0]          out_level,
  input  logic                      clear_ovf,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count
);

  function automatic logic [REC_W-1:0] pack_rec(
    input logic               gap,
    input logic [IADDR_W-1:0] iaddr,
    input logic [INSN_W-1:0]  insn,
    input logic [2:0]         priv,
    input logic               exc,
    input logic               intr,
    input logic [CAUSE_W-1:0] cause,
    input logic [IADDR_W-1:0] tval
  );
    return {gap, iaddr, insn, priv, exc, intr, cause, tval};
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input lane_cnt_t b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [PTR_W-1:0] head, tail, level, free, k_ext;
  lane_mask_t       vmask;
  lane_cnt_t        k;
  logic             push, drop, pop, gap_pend;

  logic [NLANES-1:0]       wr_en;
  logic [NLANES*AW-1:0]    wr_addr;
  logic [NLANES*REC_W-1:0] wr_data;

  always_comb begin
    vmask             = '0;
    vmask[NLANES-1:0] = in_valid;
    k                 = en ? popcount(vmask) : '0;
  end

  // Pops this cycle are not credited to free space: admission uses start-of-cycle level.
  assign level = tail - head;
  assign free  = PTR_W'(DEPTH) - level;
  assign k_ext = PTR_W'(k);
  assign push  = (k != '0) && (k_ext <= free);
  assign drop  = k_ext > free;
  assign pop   = out_valid && out_ready;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    lane_cnt_t slot;
    assign slot                       = lane_slot(vmask, i);
    assign wr_en[i]                   = push && in_valid[i];
    assign wr_addr[i*AW +: AW]        = tail[AW-1:0] + AW'(slot);
    assign wr_data[i*REC_W +: REC_W]  = pack_rec(gap_pend && (slot == '0),
                                                 in_iaddr[i*IADDR_W +: IADDR_W],
                                                 in_insn[i*INSN_W +: INSN_W],
                                                 in_priv[i*3 +: 3],
                                                 in_exception[i],
                                                 in_interrupt[i],
                                                 in_cause[i*CAUSE_W +: CAUSE_W],
                                                 in_tval[i*IADDR_W +: IADDR_W]);
  end

  trace_rec_ram #(
    .NLANES (NLANES),
    .DEPTH  (DEPTH),
    .REC_W  (REC_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (head[AW-1:0]),
    .rd_data (out_rec)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      gap_pend   <= 1'b0;
    end else begin
      if (push) begin
        tail     <= tail + k_ext;
        gap_pend <= 1'b0;
      end
      if (pop) head <= head + PTR_W'(1);
      // A drop in the same cycle as clear_ovf restarts the count at this cycle's k.
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clear_ovf ? CNT_W'(k) : sat_add(drop_count, k);
        gap_pend   <= 1'b1;
      end else if (clear_ovf) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  assign out_level = level;
  assign out_valid = (level != '0);

endmodule

// File: tb/tb_trace_retire_funnel.sv
// Directed bench for trace_retire_funnel: vector table plus multi-cycle sequences.
module tb_trace_retire_funnel;

  localparam int NL   = 2;
  localparam int DP   = 8;
  localparam int IW   = 40;
  localparam int NW   = 32;
  localparam int CW   = 64;
  localparam int CNTW = 16;
  localparam int RW   = 1 + IW + NW + 3 + 2 + CW + IW;

  logic              clk, rst_n, en, out_valid, out_ready, clear_ovf, overflow;
  logic [NL-1:0]     in_valid, in_exception, in_interrupt;
  logic [NL*IW-1:0]  in_iaddr, in_tval;
  logic [NL*NW-1:0]  in_insn;
  logic [NL*3-1:0]   in_priv;
  logic [NL*CW-1:0]  in_cause;
  logic [RW-1:0]     out_rec;
  logic [3:0]        out_level;
  logic [CNTW-1:0]   drop_count;

  trace_retire_funnel #(
    .NLANES(NL), .DEPTH(DP), .IADDR_W(IW), .INSN_W(NW), .CAUSE_W(CW), .CNT_W(CNTW)
  ) dut (
    .clock(clk), .reset(rst_n), .en(en), .in_valid(in_valid), .in_iaddr(in_iaddr),
    .in_insn(in_insn), .in_priv(in_priv), .in_exception(in_exception),
    .in_interrupt(in_interrupt), .in_cause(in_cause), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_level(out_level), .clear_ovf(clear_ovf), .overflow(overflow),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          o_gap;
  logic [IW-1:0] o_iaddr;
  logic [NW-1:0] o_insn;
  assign o_gap   = out_rec[RW-1];
  assign o_iaddr = out_rec[RW-2 -: IW];
  assign o_insn  = out_rec[RW-2-IW -: NW];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic e, input logic [1:0] v, input logic [IW-1:0] a0,
                       input logic [IW-1:0] a1, input logic r, input logic c);
    en           = e;
    in_valid     = v;
    in_iaddr     = {a1, a0};
    in_insn      = {a1[31:0] + 32'd1, a0[31:0] + 32'd1};
    in_priv      = {3'd3, 3'd0};
    in_exception = '0;
    in_interrupt = '0;
    in_cause     = '0;
    in_tval      = {a0, a1};
    out_ready    = r;
    clear_ovf    = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          en;
    logic [1:0]    vld;
    logic [IW-1:0] ia0, ia1;
    logic          rdy, clr;
    logic [3:0]    e_lvl;
    logic          e_vld, e_ovf;
    logic [15:0]   e_drop;
    logic [IW-1:0] e_ia;
    logic          e_gap;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [1:0] v, input logic [IW-1:0] a0,
                              input logic [IW-1:0] a1, input logic r, input logic c,
                              input logic [3:0] l, input logic ev, input logic eo,
                              input logic [15:0] ed, input logic [IW-1:0] eia, input logic eg);
    vec_t t;
    t.en = e; t.vld = v; t.ia0 = a0; t.ia1 = a1; t.rdy = r; t.clr = c;
    t.e_lvl = l; t.e_vld = ev; t.e_ovf = eo; t.e_drop = ed; t.e_ia = eia; t.e_gap = eg;
    return t;
  endfunction

  vec_t          vt[24];
  logic [IW-1:0] q[$];
  logic [IW-1:0] a0, a1;
  logic [1:0]    m;
  logic          rdy;
  int            sent, cyc, kk;

  initial begin
    vt[0]  = mk(1, 2'b10, 0,      40'h80000004, 0, 0, 1, 1, 0, 0, 40'h80000004, 0);
    vt[1]  = mk(1, 2'b11, 'h10,   'h14,  1, 0, 2, 1, 0, 0, 'h10,  0);
    vt[2]  = mk(1, 2'b00, 0,      0,     1, 0, 1, 1, 0, 0, 'h14,  0);
    vt[3]  = mk(1, 2'b00, 0,      0,     1, 0, 0, 0, 0, 0, 0,     0);
    vt[4]  = mk(1, 2'b11, 'h100,  'h104, 0, 0, 2, 1, 0, 0, 'h100, 0);
    vt[5]  = mk(1, 2'b11, 'h108,  'h10C, 0, 0, 4, 1, 0, 0, 'h100, 0);
    vt[6]  = mk(1, 2'b11, 'h110,  'h114, 0, 0, 6, 1, 0, 0, 'h100, 0);
    vt[7]  = mk(1, 2'b11, 'h118,  'h11C, 0, 0, 8, 1, 0, 0, 'h100, 0);
    vt[8]  = mk(1, 2'b11, 'h200,  'h204, 0, 0, 8, 1, 1, 2, 'h100, 0);
    vt[9]  = mk(1, 2'b00, 0,      0,     1, 0, 7, 1, 1, 2, 'h104, 0);
    vt[10] = mk(1, 2'b10, 0,      'h300, 0, 0, 8, 1, 1, 2, 'h104, 0);
    vt[11] = mk(1, 2'b00, 0,      0,     1, 0, 7, 1, 1, 2, 'h108, 0);
    vt[12] = mk(1, 2'b11, 'h400,  'h404, 1, 0, 6, 1, 1, 4, 'h10C, 0);
    vt[13] = mk(1, 2'b00, 0,      0,     1, 0, 5, 1, 1, 4, 'h110, 0);
    vt[14] = mk(1, 2'b00, 0,      0,     1, 0, 4, 1, 1, 4, 'h114, 0);
    vt[15] = mk(1, 2'b00, 0,      0,     1, 0, 3, 1, 1, 4, 'h118, 0);
    vt[16] = mk(1, 2'b00, 0,      0,     1, 0, 2, 1, 1, 4, 'h11C, 0);
    vt[17] = mk(1, 2'b00, 0,      0,     1, 0, 1, 1, 1, 4, 'h300, 1);
    vt[18] = mk(1, 2'b01, 'h500,  0,     0, 0, 2, 1, 1, 4, 'h300, 1);
    vt[19] = mk(1, 2'b01, 'h504,  0,     1, 0, 2, 1, 1, 4, 'h500, 1);
    vt[20] = mk(1, 2'b00, 0,      0,     1, 0, 1, 1, 1, 4, 'h504, 0);
    vt[21] = mk(1, 2'b00, 0,      0,     1, 0, 0, 0, 1, 4, 0,     0);
    vt[22] = mk(0, 2'b11, 'h600,  'h604, 0, 0, 0, 0, 1, 4, 0,     0);
    vt[23] = mk(1, 2'b00, 0,      0,     0, 1, 0, 0, 0, 0, 0,     0);

    rst_n = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0);
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(out_level), 64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].en, vt[i].vld, vt[i].ia0, vt[i].ia1, vt[i].rdy, vt[i].clr);
      step();
      chk($sformatf("v%0d_level", i), 64'(out_level),  64'(vt[i].e_lvl));
      chk($sformatf("v%0d_valid", i), 64'(out_valid),  64'(vt[i].e_vld));
      chk($sformatf("v%0d_ovf", i),   64'(overflow),   64'(vt[i].e_ovf));
      chk($sformatf("v%0d_drop", i),  64'(drop_count), 64'(vt[i].e_drop));
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d_iaddr", i), 64'(o_iaddr), 64'(vt[i].e_ia));
        chk($sformatf("v%0d_insn", i),  64'(o_insn),  64'(vt[i].e_ia[31:0] + 32'd1));
        chk($sformatf("v%0d_gap", i),   64'(o_gap),   64'(vt[i].e_gap));
      end
    end

    // Wrap: 3*DEPTH records with random ready, only admitting bursts that fit.
    sent = 0;
    cyc  = 0;
    while (sent < 3*DP && cyc < 1000) begin
      rdy = 1'($urandom_range(0, 1));
      m   = 2'($urandom_range(0, 3));
      kk  = int'(m[0]) + int'(m[1]);
      if (kk > DP - q.size()) begin
        m  = 2'b00;
        kk = 0;
      end
      a0 = '0;
      a1 = '0;
      if (m[0]) begin a0 = IW'(40'h1000 + 4*sent); q.push_back(a0); sent++; end
      if (m[1]) begin a1 = IW'(40'h1000 + 4*sent); q.push_back(a1); sent++; end
      if (q.size() > kk) chk("wrap_head", 64'(o_iaddr), 64'(q[0]));
      if (rdy && q.size() > kk) void'(q.pop_front());
      drive(1, m, a0, a1, rdy, 0);
      step();
      chk("wrap_level", 64'(out_level), 64'(q.size()));
      cyc++;
    end
    chk("wrap_sent", 64'(sent >= 3*DP), 64'd1);
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      chk("drain_head", 64'(o_iaddr), 64'(q[0]));
      void'(q.pop_front());
      drive(1, 2'b00, 0, 0, 1, 0);
      step();
      cyc++;
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("wrap_drop", 64'(drop_count), 64'd0);
    chk("wrap_ovf",  64'(overflow),   64'd0);

    // Fill, drop once, then clear_ovf collides with a second drop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b11, IW'(40'h2000 + 8*i), IW'(40'h2004 + 8*i), 0, 0);
      step();
    end
    chk("full_level", 64'(out_level), 64'd8);
    drive(1, 2'b11, 'h3000, 'h3004, 0, 0);
    step();
    chk("full_drop", 64'(drop_count), 64'd2);
    drive(1, 2'b11, 'h3008, 'h300C, 0, 1);
    step();
    chk("clr_drop_cnt", 64'(drop_count), 64'd2);
    chk("clr_drop_ovf", 64'(overflow),   64'd1);
    chk("clr_level",    64'(out_level),  64'd8);

    // Reset with records queued and gap pending.
    rst_n = 1'b0;
    drive(1, 2'b00, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    chk("mid_rst_level", 64'(out_level), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ovf",   64'(overflow),  64'd0);
    drive(1, 2'b10, 0, 'h7000, 0, 0);
    step();
    chk("post_rst_level", 64'(out_level), 64'd1);
    chk("post_rst_iaddr", 64'(o_iaddr),   64'h7000);
    chk("post_rst_gap",   64'(o_gap),     64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
